alu_arbiter: RTL and testbench

//   Shares one alu instance between NREQ requesters (e.g. integer pipe, debug/CSR unit) with

---
 rtl/alu_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_arbiter.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one ALU among NREQ valid/ready requesters, one op in flight,
// with a post-reset drain of any divide the ALU may still be running.
module alu_arbiter #(
   parameter int NREQ         = 2,
   parameter int FLUSH_CYCLES = 34
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NREQ-1:0]     req_valid,
   output logic [NREQ-1:0]     req_ready,
   input  logic [NREQ*32-1:0]  req_in1,
   input  logic [NREQ*32-1:0]  req_in2,
   input  logic [NREQ-1:0]     req_is_imm,
   input  logic [NREQ*3-1:0]   req_funct3,
   input  logic [NREQ*7-1:0]   req_funct7,
   output logic [NREQ-1:0]     resp_valid,
   input  logic [NREQ-1:0]     resp_ready,
   output logic [31:0]         resp_data,
   output logic [31:0]         alu_in1,
   output logic [31:0]         alu_in2,
   output logic                alu_is_imm,
   output logic [2:0]          alu_funct3,
   output logic [6:0]          alu_funct7,
   output logic                alu_ready,
   input  logic [31:0]         alu_out,
   input  logic                alu_done
);
   localparam int GW = $clog2(NREQ);
   localparam int CW = $clog2(FLUSH_CYCLES + 1);
   typedef enum logic [1:0] {FLUSH, IDLE, EXEC, RESP} state_t;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [GW-1:0] rr_q, rr_d, own_q, own_d;
   logic [31:0] res_q, res_d, in1_q, in1_d, in2_q, in2_d;
   logic imm_q, imm_d, alu_ready_q, alu_ready_d, found, fl;
   logic [2:0] f3_q, f3_d;
   logic [6:0] f7_q, f7_d;
   int gsel, idx;
   always_comb begin
      found = 1'b0;
      gsel  = 0;
      idx   = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = (int'(rr_q) + k) % NREQ;
         if (!found && req_valid[idx]) begin
            found = 1'b1;
            gsel  = idx;
         end
      end
   end
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rr_d        = rr_q;
      own_d       = own_q;
      res_d       = res_q;
      in1_d       = in1_q;
      in2_d       = in2_q;
      imm_d       = imm_q;
      f3_d        = f3_q;
      f7_d        = f7_q;
      alu_ready_d = 1'b0;
      req_ready   = '0;
      resp_valid  = '0;
      case (state_q)
         FLUSH: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) state_d = IDLE;
         end
         IDLE: if (found) begin
            req_ready[gsel] = 1'b1;
            own_d       = GW'(gsel);
            rr_d        = GW'((gsel + 1) % NREQ);
            in1_d       = req_in1[32*gsel +: 32];
            in2_d       = req_in2[32*gsel +: 32];
            imm_d       = req_is_imm[gsel];
            f3_d        = req_funct3[3*gsel +: 3];
            f7_d        = req_funct7[7*gsel +: 7];
            alu_ready_d = 1'b1;
            state_d     = EXEC;
         end
         EXEC: if (alu_done) begin
            res_d   = alu_out;
            state_d = RESP;
         end
         RESP: begin
            resp_valid[own_q] = 1'b1;
            if (resp_ready[own_q]) state_d = IDLE;
         end
         default: state_d = FLUSH;
      endcase
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= FLUSH;
         cnt_q       <= CW'(FLUSH_CYCLES);
         rr_q        <= '0;
         own_q       <= '0;
         res_q       <= '0;
         in1_q       <= '0;
         in2_q       <= '0;
         imm_q       <= 1'b0;
         f3_q        <= '0;
         f7_q        <= '0;
         alu_ready_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rr_q        <= rr_d;
         own_q       <= own_d;
         res_q       <= res_d;
         in1_q       <= in1_d;
         in2_q       <= in2_d;
         imm_q       <= imm_d;
         f3_q        <= f3_d;
         f7_q        <= f7_d;
         alu_ready_q <= alu_ready_d;
      end
   end
   // while flushing, present a harmless DIVU so a divide cut short by reset drains without a new start
   assign fl         = state_q == FLUSH;
   assign alu_in1    = fl ? 32'd0 : in1_q;
   assign alu_in2    = fl ? 32'd1 : in2_q;
   assign alu_is_imm = fl ? 1'b0 : imm_q;
   assign alu_funct3 = fl ? 3'b101 : f3_q;
   assign alu_funct7 = fl ? 7'b0000001 : f7_q;
   assign alu_ready  = alu_ready_q;
   assign resp_data  = res_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized scoreboard bench for alu_arbiter,
// with a behavioural ALU (single-cycle ops, ~34-cycle divides) attached.
module tb_alu_arbiter;
   localparam int NREQ  = 2;
   localparam int FLUSH = 34;
   logic clk = 1'b0, rst = 1'b0;
   logic [NREQ-1:0] req_valid = '0, req_is_imm = '0, resp_ready = '1, req_ready, resp_valid;
   logic [NREQ*32-1:0] req_in1 = '0, req_in2 = '0;
   logic [NREQ*3-1:0] req_funct3 = '0;
   logic [NREQ*7-1:0] req_funct7 = '0;
   logic [31:0] resp_data, alu_in1, alu_in2, alu_out;
   logic [2:0] alu_funct3;
   logic [6:0] alu_funct7;
   logic alu_is_imm, alu_ready, alu_done, is_div;
   logic [5:0] dcnt = '0;
   logic [31:0] dres = '0;
   int n_cmp = 0, n_fail = 0, n_start = 0, last_g = NREQ - 1, mon_g, mon_e, cnt;
   typedef struct {int id; logic [31:0] d;} exp_t;
   exp_t sb[$];
   exp_t e;

   alu_arbiter #(.NREQ(NREQ), .FLUSH_CYCLES(FLUSH)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
      .req_in1(req_in1), .req_in2(req_in2), .req_is_imm(req_is_imm),
      .req_funct3(req_funct3), .req_funct7(req_funct7), .resp_valid(resp_valid),
      .resp_ready(resp_ready), .resp_data(resp_data), .alu_in1(alu_in1), .alu_in2(alu_in2),
      .alu_is_imm(alu_is_imm), .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
      .alu_ready(alu_ready), .alu_out(alu_out), .alu_done(alu_done));

   always #5 clk = ~clk;

   function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                          input logic imm, input logic [2:0] f3, input logic [6:0] f7);
      logic signed [31:0] sa, sb_, r;
      logic ovf;
      sa  = a;
      sb_ = b;
      ovf = a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
      if (f7 == 7'd1 && !imm) begin
         case (f3)
            3'd4: begin
               if (b == 0) return 32'hFFFF_FFFF;
               if (ovf) return a;
               r = sa / sb_;
               return r;
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
               if (b == 0) return a;
               if (ovf) return 32'd0;
               r = sa % sb_;
               return r;
            end
            3'd7: return (b == 0) ? a : a % b;
            default: return a * b;
         endcase
      end
      case (f3)
         3'd0: return (!imm && f7 == 7'h20) ? a - b : a + b;
         3'd1: return a << b[4:0];
         3'd2: return {31'd0, sa < sb_};
         3'd3: return {31'd0, a < b};
         3'd4: return a ^ b;
         3'd5: begin
            if (f7 != 7'h20) return a >> b[4:0];
            r = sa >>> b[4:0];
            return r;
         end
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   // behavioural ALU: not reset, so a divide in progress survives the arbiter's reset
   assign is_div = alu_funct7 == 7'd1 && alu_funct3[2] && !alu_is_imm;
   always @(posedge clk)
      if (dcnt != 0) dcnt <= dcnt - 6'd1;
      else if (alu_ready && is_div) begin
         dcnt <= 6'd34;
         dres <= alu_fn(alu_in1, alu_in2, alu_is_imm, alu_funct3, alu_funct7);
      end
   assign alu_done = is_div ? dcnt == 6'd1 : 1'b1;
   assign alu_out  = is_div ? dres : alu_fn(alu_in1, alu_in2, alu_is_imm, alu_funct3, alu_funct7);

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // scoreboard: grants push the spec-derived result, accepted responses pop and compare
   always @(negedge clk) begin
      if (!rst) begin
         sb.delete();
         last_g = NREQ - 1;
      end else begin
         if (alu_ready) n_start++;
         if (|req_ready || |resp_valid)
            chk("onehot", $countones(req_ready) + $countones(resp_valid), 1);
         if (|req_ready) begin
            mon_g = 0;
            mon_e = -1;
            for (int i = 0; i < NREQ; i++) if (req_ready[i]) mon_g = i;
            for (int k = 1; k <= NREQ; k++)
               if (mon_e < 0 && req_valid[(last_g + k) % NREQ]) mon_e = (last_g + k) % NREQ;
            chk("rr_grant", mon_g, mon_e);
            last_g = mon_g;
            sb.push_back('{mon_g, alu_fn(req_in1[32*mon_g +: 32], req_in2[32*mon_g +: 32],
                           req_is_imm[mon_g], req_funct3[3*mon_g +: 3], req_funct7[7*mon_g +: 7])});
         end
         for (int i = 0; i < NREQ; i++)
            if (resp_valid[i] && resp_ready[i]) begin
               if (sb.size() == 0) begin
                  n_cmp++;
                  n_fail++;
                  $display("FAIL resp_unexpected: got response for %0d, required none", i);
               end else begin
                  e = sb.pop_front();
                  chk("resp_owner", i, e.id);
                  chk("resp_data", resp_data, e.d);
               end
            end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic imm, input logic [2:0] f3, input logic [6:0] f7);
      req_in1[32*i +: 32] = a;
      req_in2[32*i +: 32] = b;
      req_is_imm[i]       = imm;
      req_funct3[3*i +: 3] = f3;
      req_funct7[7*i +: 7] = f7;
   endtask

   task automatic wait_for(input string nm, input bit resp, input int i, input int lim);
      for (int c = 0; c < lim; c++) begin
         @(negedge clk);
         if (resp ? resp_valid[i] : req_ready[i]) return;
      end
      n_cmp++;
      n_fail++;
      $display("FAIL %s: timeout after %0d cycles, required event on %0d", nm, lim, i);
   endtask

   task automatic run_op(input string nm, input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] f3, input logic [6:0] f7, input logic [31:0] exp, input int lim);
      int s0;
      set_op(i, a, b, 1'b0, f3, f7);
      req_valid[i] = 1'b1;
      wait_for({nm, "_grant"}, 1'b0, i, lim);
      s0 = n_start;
      tick();
      req_valid = '0;
      wait_for({nm, "_resp"}, 1'b1, i, lim);
      chk({nm, "_data"}, resp_data, exp);
      chk({nm, "_starts"}, n_start - s0, 1);
      tick();
   endtask

   task automatic rand_op(input int i);
      int k;
      logic [31:0] a, b;
      logic [2:0] f3;
      logic [6:0] f7;
      logic imm;
      k   = $urandom_range(0, 13);
      a   = ($urandom_range(0, 15) == 0) ? 32'h8000_0000 : $urandom;
      b   = ($urandom_range(0, 7) == 0) ? 32'd0 : ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom;
      imm = 1'b0;
      f7  = 7'd0;
      if (k < 4) begin
         f7 = 7'd1;
         f3 = 3'(4 + k);
      end else begin
         f3  = 3'($urandom_range(0, 7));
         imm = 1'($urandom);
         if ((f3 == 3'd0 || f3 == 3'd5) && $urandom_range(0, 1) == 1) f7 = 7'h20;
      end
      set_op(i, a, b, imm, f3, f7);
   endtask

   initial begin
      set_op(0, 32'd5, 32'd7, 1'b0, 3'd0, 7'd0);
      req_valid = 2'b01;
      repeat (3) @(negedge clk);
      chk("rst_req_ready", req_ready, 0);
      chk("rst_resp_valid", resp_valid, 0);
      chk("rst_resp_data", resp_data, 0);
      chk("rst_alu_ready", alu_ready, 0);
      chk("rst_flush_f3", alu_funct3, 3'b101);
      tick();
      rst = 1'b1;
      cnt = 0;
      @(negedge clk);
      while (req_ready == '0 && cnt < 100) begin
         cnt++;
         @(negedge clk);
      end
      chk("flush_len", cnt, FLUSH);
      chk("t2_grant", req_ready, 2'b01);
      tick();
      req_valid = '0;
      @(negedge clk);
      chk("t2_alu_ready", alu_ready, 1);
      chk("t2_alu_in1", alu_in1, 5);
      @(negedge clk);
      chk("t2_resp_valid", resp_valid, 2'b01);
      chk("t2_data", resp_data, 12);
      tick();
      @(negedge clk);
      chk("t2_idle", resp_valid, 0);
      // both requesters contending: grants must alternate every 3 cycles
      tick();
      set_op(0, 32'd100, 32'd1, 1'b0, 3'd0, 7'd0);
      set_op(1, 32'd200, 32'd2, 1'b0, 3'd0, 7'd0);
      req_valid = '1;
      wait_for("t3_first", 1'b0, 1, 10);
      for (int k = 0; k < 6; k++) begin
         chk("t3_grant", req_ready, (k % 2 == 0) ? 2'b10 : 2'b01);
         repeat (3) @(negedge clk);
      end
      tick();
      req_valid = '0;
      repeat (4) tick();
      run_op("t4_div", 1, 32'hFFFF_FFEC, 32'd3, 3'd4, 7'd1, 32'hFFFF_FFFA, 100);
      run_op("t4_rem", 1, 32'hFFFF_FFEC, 32'd3, 3'd6, 7'd1, 32'hFFFF_FFFE, 100);
      // response backpressure must freeze the bus and block the other requester
      resp_ready = '0;
      set_op(0, 32'd3, 32'd4, 1'b0, 3'd0, 7'd0);
      req_valid = 2'b01;
      wait_for("t5_grant", 1'b0, 0, 10);
      tick();
      set_op(1, 32'd9, 32'd9, 1'b0, 3'd0, 7'd0);
      req_valid = 2'b10;
      wait_for("t5_resp", 1'b1, 0, 10);
      for (int k = 0; k < 10; k++) begin
         chk("t5_hold_valid", resp_valid, 2'b01);
         chk("t5_hold_data", resp_data, 7);
         chk("t5_no_grant", req_ready, 0);
         @(negedge clk);
      end
      tick();
      resp_ready = 2'b01;
      tick();
      resp_ready = '1;
      wait_for("t5_g1", 1'b0, 1, 10);
      tick();
      req_valid = '0;
      repeat (3) tick();
      // reset in the middle of a divide, then a clean divide after the flush
      set_op(0, 32'd1000, 32'd3, 1'b0, 3'd5, 7'd1);
      req_valid = 2'b01;
      wait_for("t6_grant", 1'b0, 0, 10);
      tick();
      req_valid = '0;
      repeat (10) @(negedge clk);
      tick();
      rst = 1'b0;
      @(negedge clk);
      chk("t6_rst_req_ready", req_ready, 0);
      chk("t6_rst_resp_valid", resp_valid, 0);
      chk("t6_rst_resp_data", resp_data, 0);
      chk("t6_rst_alu_ready", alu_ready, 0);
      tick();
      rst = 1'b1;
      run_op("t6_divu", 0, 32'd100, 32'd7, 3'd5, 7'd1, 32'd14, 200);
      for (int c = 0; c < 1500; c++) begin
         tick();
         for (int i = 0; i < NREQ; i++) rand_op(i);
         req_valid  = NREQ'($urandom);
         resp_ready = NREQ'($urandom);
      end
      tick();
      req_valid  = '0;
      resp_ready = '1;
      for (int c = 0; c < 100 && (sb.size() != 0 || resp_valid != 0); c++) tick();
      chk("drain_empty", sb.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1);
   end
endmodule
